mem_write_arbiter: RTL and testbench
====================================

# mem_write_arbiter

Shares the data memory's single write port (`mem_write_enable`/`write_addr`/`write_data`) between two requesters: requester 0 is the CPU store path, requester 1 is the peripheral updater, e.g. the SSD/sensor mailbox writer. Each requester has its own small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs at up to one memory write per cycle. Writes to out-of-range addresses or to the read-only sensor word are dropped and flagged, never forwarded.

## Interface
- `MEM_DEPTH`, 1024: number of 32-bit memory words; legal addresses are 0..MEM_DEPTH-1.
- `RO_ADDR`, 1001: read-only word (sensor input); writes to it are dropped.
- `FIFO_DEPTH`, 2: entries per requester FIFO; must be a power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 presents a write.
- `req0_ready` output 1: requester 0 FIFO can accept.
- `req0_addr` input 32: word address.
- `req0_data` input 32: write data.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1.
- `mem_write_enable` output 1: registered write strobe to the memory.
- `write_addr` output 32: registered address to the memory.
- `write_data` output 32: registered data to the memory.
- `busy` output 1: either FIFO is non-empty, or `mem_write_enable` is high.
- `err_pulse` output 1: one-cycle pulse when an entry is dropped.
- `err_src` output 1: requester whose entry was dropped; valid while `err_pulse` is high.
- `drop_count` output 8: saturating count of dropped entries, both requesters combined.

## Operation
- **Acceptance:** a FIFO accepts an entry on a rising edge when `reqN_valid && reqN_ready`.
- **Ready:** `reqN_ready = !fullN`. It is independent of `reqN_valid` and of a same-cycle pop, so a full FIFO never accepts, even while being drained.
- **Ordering:** FIFOs preserve order within each requester. There is no ordering guarantee across requesters.
- **Arbitration:** combinational, each cycle, over the FIFO heads.
  - One FIFO non-empty: it wins.
  - Both non-empty: the requester not granted last wins.
  - `last_grant` updates only on a grant.
- **Grant:** the winning head is popped on that edge.
- **Legal entry:** if the address is below `MEM_DEPTH` and not equal to `RO_ADDR`:
  - next cycle: `mem_write_enable=1`, with `write_addr`/`write_data` set to the entry.
- **Illegal entry:**
  - next cycle: `mem_write_enable=0`, `err_pulse=1`, `err_src` = winner.
  - `drop_count` increments and saturates at 255.
  - The grant slot is consumed and `last_grant` advances.
- **No grant:** `mem_write_enable=0` and `err_pulse=0`. `write_addr`/`write_data` hold their last values.
- **Address width:** addresses are compared as unsigned 32-bit values. The full 32 bits are forwarded; the memory uses the low bits.
- **Reset (any time, including mid-transfer):**
  - FIFOs are flushed, and pending entries are discarded without a write.
  - `mem_write_enable`, `err_pulse` and `err_src` go to 0.
  - `write_addr` and `write_data` go to 0.
  - `drop_count` goes to 0.
  - `last_grant` goes to 1, so requester 0 wins the first tie.
  - `reqN_ready` goes to 1 once `rst` is low.

## Timing
- **Latency:** an entry accepted at edge E into an empty FIFO, with no competition, is granted at E+1. `mem_write_enable` is high from E+1 to E+2, and the memory commits it at E+2.
- **Throughput:** at most one grant per cycle. Under contention the grants alternate 0,1,0,1.
- **Strobe:** `mem_write_enable` is never high for two cycles from one entry. Back-to-back high cycles carry distinct entries.
- **Idle:** `busy` falls in the cycle after the last write strobe.
- **Same-edge push and pop:**
  - On a non-full FIFO, both a push and a pop are allowed; occupancy is unchanged.
  - On an empty FIFO, the pushed entry cannot be granted on the same edge.

## Test plan
- **Reset values:** assert `rst` → all outputs 0 except both `reqN_ready`=1. Drive `req0` (addr 5, data 0xA5) for one cycle → exactly one `mem_write_enable` pulse with addr 5 / data 0xA5, starting one edge after acceptance.
- **Contention:** both requesters stream 4 writes each every cycle → strobes alternate 0,1,0,1,… starting with req0. The 8 writes complete in order within each requester. Each `reqN_ready` drops while its FIFO is full.
- **Illegal addresses:** req1 writes addr 1001, then addr 1024 → two `err_pulse` with `err_src`=1, `drop_count`=2, and no `mem_write_enable`. A following req1 write to addr 1000 (data 7) is issued normally.
- **Saturation:** 300 illegal writes → `drop_count` stays at 255.
- **Reset mid-operation:** fill both FIFOs, assert `rst` mid-stream → `mem_write_enable` drops immediately. No queued entry is written after `rst` deasserts, and `busy`=0.
- **Back-pressure:** hold `req0_valid` with `req0_ready`=0 (FIFO full) → the entry is not accepted until `req0_ready`=1. No duplicate or lost writes.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// Two-requester write arbiter: per-requester FIFOs drained round-robin into one memory write port.
// Entries aimed outside the memory or at the read-only sensor word are dropped, flagged and counted.
module mem_write_arbiter #(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned RO_ADDR    = 1001,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_data,
  output logic        mem_write_enable,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        err_pulse,
  output logic        err_src,
  output logic [7:0]  drop_count
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [63:0] fifo_mem [2][FIFO_DEPTH];
  logic [PW:0] wr_ptr [2];
  logic [PW:0] rd_ptr [2];
  logic [63:0] entry_in [2];
  logic [1:0]  valid_in;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [1:0]  grant;
  logic        last_grant;
  logic        winner;
  logic        any_grant;
  logic        legal;
  logic [63:0] head;

  assign entry_in[0] = {req0_addr, req0_data};
  assign entry_in[1] = {req1_addr, req1_data};
  assign valid_in    = {req1_valid, req0_valid};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                 (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
    end
  end

  assign push       = valid_in & ~full;
  assign req0_ready = !full[0];
  assign req1_ready = !full[1];

  // On a tie the requester that was not granted last wins.
  assign grant[0]  = !empty[0] && (empty[1] || last_grant);
  assign grant[1]  = !empty[1] && (empty[0] || !last_grant);
  assign any_grant = |grant;
  assign winner    = grant[1];
  assign head      = fifo_mem[winner][rd_ptr[winner][PW-1:0]];
  assign legal     = (head[63:32] < 32'(MEM_DEPTH)) && (head[63:32] != 32'(RO_ADDR));

  assign busy = (|(~empty)) || mem_write_enable;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i][PW-1:0]] <= entry_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      last_grant <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + (PW+1)'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + (PW+1)'(1);
      end
      if (any_grant) last_grant <= winner;
    end
  end

  // Illegal entries still consume their grant slot but never reach the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_enable <= 1'b0;
      write_addr       <= '0;
      write_data       <= '0;
      err_pulse        <= 1'b0;
      err_src          <= 1'b0;
      drop_count       <= '0;
    end else begin
      mem_write_enable <= any_grant && legal;
      err_pulse        <= any_grant && !legal;
      if (any_grant && legal) begin
        write_addr <= head[63:32];
        write_data <= head[31:0];
      end
      if (any_grant && !legal) begin
        err_src <= winner;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter: table-driven single writes plus scoreboarded streams.
module tb_mem_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        mem_write_enable;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        err_pulse;
  logic        err_src;
  logic [7:0]  drop_count;

  mem_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .mem_write_enable(mem_write_enable), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .err_pulse(err_pulse), .err_src(err_src), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_we;
    logic        exp_err;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t        vecs [9];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  bit          src_log [$];
  int          err_exp [2];
  int          checks = 0;
  int          errors = 0;
  int          low0 = 0;
  int          low1 = 0;
  int          tag = 0;
  logic [63:0] mon_got;

  function automatic logic legal_addr(input logic [31:0] a);
    return (a < 32'd1024) && (a != 32'd1001);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic src, input logic [31:0] a, input logic [31:0] d);
    if (!legal_addr(a)) err_exp[src]++;
    else if (src) q1.push_back({a, d});
    else q0.push_back({a, d});
  endtask

  // Scoreboard: every strobe must match the oldest outstanding entry of one requester.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_enable) begin
        checks++;
        mon_got = {write_addr, write_data};
        if (q0.size() > 0 && q0[0] == mon_got) begin
          void'(q0.pop_front());
          src_log.push_back(1'b0);
        end else if (q1.size() > 0 && q1[0] == mon_got) begin
          void'(q1.pop_front());
          src_log.push_back(1'b1);
        end else begin
          errors++;
          $display("[TB] FAIL write_scoreboard actual=%h/%h required=an outstanding entry", write_addr, write_data);
        end
      end
      if (err_pulse) begin
        checks++;
        if (mem_write_enable || err_exp[err_src] == 0) begin
          errors++;
          $display("[TB] FAIL err_scoreboard actual=src %0d we %0d required=an outstanding drop, no strobe", err_src, mem_write_enable);
        end else begin
          err_exp[err_src]--;
        end
      end
    end
  end

  task automatic clear_expect();
    q0.delete();
    q1.delete();
    err_exp[0] = 0;
    err_exp[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_expect();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_idle"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_output({name, "_q0_drained"}, 32'(q0.size()), 32'd0);
    check_output({name, "_q1_drained"}, 32'(q1.size()), 32'd0);
    check_output({name, "_drops_seen"}, 32'(err_exp[0] + err_exp[1]), 32'd0);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    @(negedge clk);
    if (v.src) begin
      req1_valid = 1'b1; req1_addr = v.addr; req1_data = v.data;
      check_output($sformatf("vec%0d_ready", idx), 32'(req1_ready), 32'd1);
    end else begin
      req0_valid = 1'b1; req0_addr = v.addr; req0_data = v.data;
      check_output($sformatf("vec%0d_ready", idx), 32'(req0_ready), 32'd1);
    end
    if (v.exp_we) begin
      if (v.src) q1.push_back({v.addr, v.data});
      else q0.push_back({v.addr, v.data});
    end else begin
      err_exp[v.src]++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_output($sformatf("vec%0d_no_same_edge", idx), 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    check_output($sformatf("vec%0d_we", idx), 32'(mem_write_enable), 32'(v.exp_we));
    check_output($sformatf("vec%0d_err", idx), 32'(err_pulse), 32'(v.exp_err));
    if (v.exp_err) check_output($sformatf("vec%0d_err_src", idx), 32'(err_src), 32'(v.src));
    if (v.exp_we) begin
      check_output($sformatf("vec%0d_addr", idx), write_addr, v.addr);
      check_output($sformatf("vec%0d_data", idx), write_data, v.data);
    end
    check_output($sformatf("vec%0d_drop", idx), 32'(drop_count), 32'(v.exp_drop));
    check_output($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.exp_we));
    @(negedge clk);
    check_output($sformatf("vec%0d_single_strobe", idx), 32'(mem_write_enable), 32'd0);
    check_output($sformatf("vec%0d_err_cleared", idx), 32'(err_pulse), 32'd0);
    check_output($sformatf("vec%0d_busy_fall", idx), 32'(busy), 32'd0);
  endtask

  // Streams n0/n1 entries; a requester holds its entry until it sees ready.
  task automatic stream(input int n0, input int n1, input logic [31:0] a0, input logic [31:0] s0,
                        input logic [31:0] a1, input logic [31:0] s1);
    int i0 = 0;
    int i1 = 0;
    int guard = 0;
    tag++;
    while ((i0 < n0 || i1 < n1) && guard < 5000) begin
      @(negedge clk);
      guard++;
      req0_valid = (i0 < n0);
      req0_addr  = a0 + s0 * 32'(i0);
      req0_data  = {4'hA, 12'(tag), 16'(i0)};
      req1_valid = (i1 < n1);
      req1_addr  = a1 + s1 * 32'(i1);
      req1_data  = {4'hB, 12'(tag), 16'(i1)};
      if (req0_valid && req0_ready) begin
        expect_entry(1'b0, req0_addr, req0_data);
        i0++;
      end else if (req0_valid) low0++;
      if (req1_valid && req1_ready) begin
        expect_entry(1'b1, req1_addr, req1_data);
        i1++;
      end else if (req1_valid) low1++;
    end
    check_output("stream_timeout", 32'(guard < 5000), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int strobes;
    vecs[0] = '{1'b0, 32'd5,          32'hA5, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 32'd1001,       32'hB1, 1'b0, 1'b1, 8'd1};
    vecs[2] = '{1'b1, 32'd1024,       32'hB2, 1'b0, 1'b1, 8'd2};
    vecs[3] = '{1'b1, 32'd1000,       32'd7,  1'b1, 1'b0, 8'd2};
    vecs[4] = '{1'b0, 32'd0,          32'h11, 1'b1, 1'b0, 8'd2};
    vecs[5] = '{1'b0, 32'd1023,       32'h22, 1'b1, 1'b0, 8'd2};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'h33, 1'b0, 1'b1, 8'd3};
    vecs[7] = '{1'b0, 32'd1001,       32'h44, 1'b0, 1'b1, 8'd4};
    vecs[8] = '{1'b0, 32'd1002,       32'h55, 1'b1, 1'b0, 8'd4};
    err_exp[0] = 0;
    err_exp[1] = 0;

    repeat (2) @(negedge clk);
    check_output("rst_we", 32'(mem_write_enable), 32'd0);
    check_output("rst_addr", write_addr, 32'd0);
    check_output("rst_data", write_data, 32'd0);
    check_output("rst_err", 32'(err_pulse), 32'd0);
    check_output("rst_err_src", 32'(err_src), 32'd0);
    check_output("rst_drop", 32'(drop_count), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_ready0", 32'(req0_ready), 32'd1);
    check_output("rst_ready1", 32'(req1_ready), 32'd1);

    for (int i = 0; i < 9; i++) apply_stimulus(i, vecs[i]);
    wait_idle("table");

    $display("[TB] contention");
    do_reset();
    src_log.delete();
    low0 = 0;
    low1 = 0;
    stream(4, 4, 32'd10, 32'd1, 32'd20, 32'd1);
    wait_idle("contention");
    check_output("contention_count", 32'(src_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < src_log.size(); i++)
      check_output($sformatf("contention_order%0d", i), 32'(src_log[i]), 32'(i % 2));
    check_output("ready0_dropped", 32'(low0 > 0), 32'd1);
    check_output("ready1_dropped", 32'(low1 > 0), 32'd1);

    $display("[TB] back-pressure with drops");
    low0 = 0;
    stream(6, 6, 32'd300, 32'd1, 32'd5000, 32'd1);
    wait_idle("backpressure");
    check_output("backpressure_ready0_low", 32'(low0 > 0), 32'd1);
    check_output("backpressure_drop", 32'(drop_count), 32'd6);

    $display("[TB] saturation");
    stream(0, 300, 32'd0, 32'd0, 32'd1001, 32'd0);
    wait_idle("saturation");
    check_output("saturation_drop", 32'(drop_count), 32'd255);

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 32'(100 + k); req0_data = 32'(32'hC0 + k);
      req1_valid = 1'b1; req1_addr = 32'(200 + k); req1_data = 32'(32'hD0 + k);
      if (req0_ready) expect_entry(1'b0, req0_addr, req0_data);
      if (req1_ready) expect_entry(1'b1, req1_addr, req1_data);
    end
    @(posedge clk);
    #2;
    check_output("reset_pre_we", 32'(mem_write_enable), 32'd1);
    rst = 1'b1;
    #1;
    check_output("reset_we_async", 32'(mem_write_enable), 32'd0);
    check_output("reset_addr_async", write_addr, 32'd0);
    clear_expect();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_write_enable || err_pulse) strobes++;
    end
    check_output("reset_no_writes", 32'(strobes), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_drop", 32'(drop_count), 32'd0);
    check_output("reset_ready0", 32'(req0_ready), 32'd1);
    check_output("reset_ready1", 32'(req1_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
